// File: rtl/id_ex_ctrl_stage.sv
// id_ex_ctrl_stage
//
// Registered ID/EX control-bundle stage with hazard-driven bubble insertion.
// It sits between the main control decoder and the EX stage. A single hazard
// request with a length inserts that many consecutive bubbles. While the
// bubbles are being inserted, stall_o holds the PC and IF/ID. A branch flush
// squashes the bundle and aborts any bubble sequence in progress.
//
// Handshake: valid_o qualifies the registered bundle, which has one cycle of
// latency. stall_o is combinational. While it is high, the upstream stages
// must hold their current instruction. That instruction is sampled again on
// the edge after the last stall cycle.
//
// Optional feature: define CTRL_PERF_CNT_EN to add bubble_cnt_o. This is a
// saturating count of the hazard bubbles that were registered. Flush bubbles
// are not counted.

module id_ex_ctrl_stage #(
  parameter int WB_W  = 2,
  parameter int M_W   = 2,
  parameter int EX_W  = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WB_W-1:0]  wb_i,
  input  logic [M_W-1:0]   m_i,
  input  logic [EX_W-1:0]  ex_i,
  input  logic             valid_i,
  input  logic             hazard_i,
  input  logic [CNT_W-1:0] hazard_len_i,
  input  logic             flush_i,
  output logic [WB_W-1:0]  WB_o,
  output logic [M_W-1:0]   M_o,
  output logic [EX_W-1:0]  EX_o,
  output logic             valid_o,
  output logic             stall_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]      bubble_cnt_o
`endif
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] BUBBLE = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] len;
  logic [WB_W-1:0]  wb_nxt;
  logic [M_W-1:0]   m_nxt;
  logic [EX_W-1:0]  ex_nxt;
  logic             valid_nxt;
  logic             hazard_bubble;

  // A requested length of zero still costs one bubble.
  always_comb begin
    len = (hazard_len_i == '0) ? CNT_W'(1) : hazard_len_i;
  end

  // Next-state and next-bundle selection. The default is a bubble.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    wb_nxt        = '0;
    m_nxt         = '0;
    ex_nxt        = '0;
    valid_nxt     = 1'b0;
    hazard_bubble = 1'b0;
    case (state)
      RUN: begin
        if (flush_i) begin
          state_nxt = RUN;
        end else if (hazard_i && valid_i) begin
          // The first bubble is this cycle; cnt keeps the remainder.
          hazard_bubble = 1'b1;
          cnt_nxt       = len - CNT_W'(1);
          state_nxt     = (len > CNT_W'(1)) ? BUBBLE : RUN;
        end else if (valid_i) begin
          wb_nxt    = wb_i;
          m_nxt     = m_i;
          ex_nxt    = ex_i;
          valid_nxt = 1'b1;
        end
      end
      BUBBLE: begin
        if (flush_i) begin
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          hazard_bubble = 1'b1;
          // cnt==0 cannot happen here, but leaving on it too means the
          // counter can never wrap around to the maximum.
          if (cnt <= CNT_W'(1)) begin
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
    endcase
  end

  // State, remaining-bubble counter and the registered control bundle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= RUN;
      cnt     <= '0;
      WB_o    <= '0;
      M_o     <= '0;
      EX_o    <= '0;
      valid_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      WB_o    <= wb_nxt;
      M_o     <= m_nxt;
      EX_o    <= ex_nxt;
      valid_o <= valid_nxt;
    end
  end

  // Stall upstream during every hazard bubble. A flush wins, and so does reset.
  always_comb begin
    stall_o = !rst_i && !flush_i &&
              (((state == RUN) && hazard_i && valid_i) || (state == BUBBLE));
  end

`ifdef CTRL_PERF_CNT_EN
  // Saturating count of the hazard bubbles that were registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_o <= '0;
    end else if (hazard_bubble && (bubble_cnt_o != 32'hFFFF_FFFF)) begin
      bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`else
  logic unused_hazard_bubble;
  // hazard_bubble only feeds the optional counter.
  always_comb begin
    unused_hazard_bubble = hazard_bubble;
  end
`endif

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Testbench for id_ex_ctrl_stage. It uses directed vectors and checks them
// with a scoreboard. The checks of the optional counter are enabled when
// CTRL_PERF_CNT_EN is defined.

module tb_id_ex_ctrl_stage;

  localparam int W = 9; // {valid, wb[1:0], m[1:0], ex[3:0]}

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] wb_i, m_i;
  logic [3:0] ex_i;
  logic       valid_i, hazard_i, flush_i;
  logic [2:0] hazard_len_i;
  logic [1:0] WB_o, M_o;
  logic [3:0] EX_o;
  logic       valid_o, stall_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] bubble_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic         stall_q[$];

  id_ex_ctrl_stage dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wb_i         (wb_i),
    .m_i          (m_i),
    .ex_i         (ex_i),
    .valid_i      (valid_i),
    .hazard_i     (hazard_i),
    .hazard_len_i (hazard_len_i),
    .flush_i      (flush_i),
    .WB_o         (WB_o),
    .M_o          (M_o),
    .EX_o         (EX_o),
    .valid_o      (valid_o),
    .stall_o      (stall_o)
`ifdef CTRL_PERF_CNT_EN
    ,
    .bubble_cnt_o (bubble_cnt_o)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply one vector at the falling edge and push its expectations.
  task automatic step(input logic [1:0] wb, input logic [1:0] m, input logic [3:0] ex,
                      input logic v, input logic hz, input logic [2:0] len,
                      input logic fl, input logic exp_stall, input logic [W-1:0] exp_out);
    @(negedge clk);
    wb_i = wb; m_i = m; ex_i = ex; valid_i = v;
    hazard_i = hz; hazard_len_i = len; flush_i = fl;
    stall_q.push_back(exp_stall);
    exp_q.push_back(exp_out);
  endtask

  // Monitor for stall, which depends on the current cycle's inputs.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (stall_q.size() > 0) check("stall_o", 32'(stall_o), 32'(stall_q.pop_front()));
    end
  end

  // Monitor for the registered bundle, sampled 1 after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("bundle", 32'({valid_o, WB_o, M_o, EX_o}), 32'(exp_q.pop_front()));
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [W-1:0] BUB = '0;

  initial begin
    // Reset block. A hazard is driven during reset to check that it is gated.
    rst = 1'b1;
    wb_i = 2'b11; m_i = 2'b11; ex_i = 4'hF; valid_i = 1'b1;
    hazard_i = 1'b1; hazard_len_i = 3'd3; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_bundle", 32'({valid_o, WB_o, M_o, EX_o}), 32'(BUB));
    check("reset_stall", 32'(stall_o), 32'd0);
`ifdef CTRL_PERF_CNT_EN
    check("reset_perf", bubble_cnt_o, 32'd0);
`endif
    @(negedge clk);
    hazard_i = 1'b0; valid_i = 1'b0;
    rst = 1'b0;

    // Pass-through
    step(2'b11, 2'b10, 4'b1011, 1, 0, 3'd0, 0, 0, {1'b1, 2'b11, 2'b10, 4'b1011});
    // Invalid slot: controls are zeroed
    step(2'b11, 2'b11, 4'b1111, 0, 0, 3'd0, 0, 0, BUB);

    // Load-use hazard of length 1, then the held instruction
    step(2'b10, 2'b01, 4'b0110, 1, 1, 3'd1, 0, 1, BUB);
    step(2'b10, 2'b01, 4'b0110, 1, 0, 3'd0, 0, 0, {1'b1, 2'b10, 2'b01, 4'b0110});

    // Length 5. hazard_i stays high but is ignored while bubbling.
    step(2'b01, 2'b00, 4'b1100, 1, 1, 3'd5, 0, 1, BUB);
    for (int i = 0; i < 4; i++) step(2'b01, 2'b00, 4'b1100, 1, 1, 3'd3, 0, 1, BUB);
    step(2'b01, 2'b00, 4'b1100, 1, 0, 3'd0, 0, 0, {1'b1, 2'b01, 2'b00, 4'b1100});

    // Length 0 behaves as length 1
    step(2'b11, 2'b01, 4'b0011, 1, 1, 3'd0, 0, 1, BUB);
    step(2'b11, 2'b01, 4'b0011, 1, 0, 3'd0, 0, 0, {1'b1, 2'b11, 2'b01, 4'b0011});

    // A hazard with valid_i=0 is ignored
    step(2'b11, 2'b11, 4'b1111, 0, 1, 3'd4, 0, 0, BUB);
    step(2'b00, 2'b11, 4'b0101, 1, 0, 3'd0, 0, 0, {1'b1, 2'b00, 2'b11, 4'b0101});

    // Flush on the 2nd cycle of a 4-bubble sequence
    step(2'b10, 2'b10, 4'b1001, 1, 1, 3'd4, 0, 1, BUB);
    step(2'b10, 2'b10, 4'b1001, 1, 0, 3'd0, 1, 0, BUB);
    step(2'b10, 2'b10, 4'b1001, 1, 0, 3'd0, 0, 0, {1'b1, 2'b10, 2'b10, 4'b1001});

    // Flush at the same time as a hazard
    step(2'b01, 2'b11, 4'b0111, 1, 1, 3'd3, 1, 0, BUB);
    step(2'b01, 2'b11, 4'b0111, 1, 0, 3'd0, 0, 0, {1'b1, 2'b01, 2'b11, 4'b0111});

    // Maximum length of 7, then the held instruction
    step(2'b11, 2'b00, 4'b1110, 1, 1, 3'd7, 0, 1, BUB);
    for (int i = 0; i < 6; i++) step(2'b11, 2'b00, 4'b1110, 1, 0, 3'd0, 0, 1, BUB);
    step(2'b11, 2'b00, 4'b1110, 1, 0, 3'd0, 0, 0, {1'b1, 2'b11, 2'b00, 4'b1110});

    // Perf count: 1 + 5 + 1 + 1 + 7 = 15 hazard bubbles
    @(negedge clk);
    valid_i = 1'b0; hazard_i = 1'b0;
`ifdef CTRL_PERF_CNT_EN
    @(posedge clk); #1;
    check("perf_count", bubble_cnt_o, 32'd15);
`endif

    // Assert reset asynchronously in the middle of a bubble sequence
    step(2'b10, 2'b11, 4'b1101, 1, 1, 3'd4, 0, 1, BUB);
    step(2'b10, 2'b11, 4'b1101, 1, 0, 3'd0, 0, 1, BUB);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_stall", 32'(stall_o), 32'd0);
    check("async_rst_bundle", 32'({valid_o, WB_o, M_o, EX_o}), 32'(BUB));
`ifdef CTRL_PERF_CNT_EN
    check("async_rst_perf", bubble_cnt_o, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    // The first cycle after release is RUN, so there is no stall
    step(2'b10, 2'b11, 4'b1101, 1, 0, 3'd0, 0, 0, {1'b1, 2'b10, 2'b11, 4'b1101});
    step(2'b00, 2'b00, 4'b0000, 0, 0, 3'd0, 0, 0, BUB);

    // Drain with a bounded wait
    for (int i = 0; i < 10 && (exp_q.size() > 0 || stall_q.size() > 0); i++) @(posedge clk);
    #2;
    check("queues_drained", 32'(exp_q.size() + stall_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
